// File: rtl/iob_iob2axi_single.sv
// Single-beat IOb-to-AXI4 master bridge: one outstanding read or write, each a LEN=0 INCR burst.
// Define IOB2AXI_ERR_EN to enable the sticky err_o flag for non-OKAY B/R responses.
module iob_iob2axi_single #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8,
    parameter int LEN_W  = 8,
    parameter int AXI_ID = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                iob_valid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic [ADDR_W-1:0]   axi_awaddr_o,
    output logic [ID_W-1:0]     axi_awid_o,
    output logic [LEN_W-1:0]    axi_awlen_o,
    output logic [2:0]          axi_awsize_o,
    output logic [1:0]          axi_awburst_o,
    output logic                axi_awvalid_o,
    input  logic                axi_awready_i,
    output logic [DATA_W-1:0]   axi_wdata_o,
    output logic [DATA_W/8-1:0] axi_wstrb_o,
    output logic                axi_wlast_o,
    output logic                axi_wvalid_o,
    input  logic                axi_wready_i,
    input  logic [1:0]          axi_bresp_i,
    input  logic [ID_W-1:0]     axi_bid_i,
    input  logic                axi_bvalid_i,
    output logic                axi_bready_o,
    output logic [ADDR_W-1:0]   axi_araddr_o,
    output logic [ID_W-1:0]     axi_arid_o,
    output logic [LEN_W-1:0]    axi_arlen_o,
    output logic [2:0]          axi_arsize_o,
    output logic [1:0]          axi_arburst_o,
    output logic                axi_arvalid_o,
    input  logic                axi_arready_i,
    input  logic [DATA_W-1:0]   axi_rdata_i,
    input  logic [1:0]          axi_rresp_i,
    input  logic [ID_W-1:0]     axi_rid_i,
    input  logic                axi_rlast_i,
    input  logic                axi_rvalid_i,
    output logic                axi_rready_o,
    output logic                err_o,
    input  logic                err_clr_i
);
    localparam int         STRB_W   = DATA_W / 8;
    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                arvalid_q, arvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic                unused_s;

    // Next-state and payload logic; AW and W channels retire independently in WRITE.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iob_valid_i) begin
                    addr_d = iob_addr_i;
                    if (|iob_wstrb_i) begin
                        wdata_d   = iob_wdata_i;
                        wstrb_d   = iob_wstrb_i;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                awvalid_d = awvalid_q & ~axi_awready_i;
                wvalid_d  = wvalid_q & ~axi_wready_i;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = WRESP;
                end else begin
                    state_d = WRITE;
                end
            end
            WRESP: begin
                if (axi_bvalid_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = WRESP;
                end
            end
            RADDR: begin
                if (axi_arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = RDATA;
                end else begin
                    state_d = RADDR;
                end
            end
            RDATA: begin
                if (axi_rvalid_i) begin
                    rdata_d  = axi_rdata_i;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = RDATA;
                end
            end
            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase
    end

`ifdef IOB2AXI_ERR_EN
    // Sticky error flag; a same-cycle error beat overrides a clear request.
    always_comb begin
        err_d = ((state_q == WRESP) && axi_bvalid_i && (axi_bresp_i != 2'b00))
              | ((state_q == RDATA) && axi_rvalid_i && (axi_rresp_i != 2'b00))
              | (err_q & ~err_clr_i);
    end
    assign unused_s = ^{axi_bid_i, axi_rid_i, axi_rlast_i};
`else
    // Error reporting compiled out: flag held clear.
    always_comb begin
        err_d = 1'b0;
    end
    assign unused_s = ^{axi_bid_i, axi_rid_i, axi_rlast_i, axi_bresp_i, axi_rresp_i, err_clr_i};
`endif

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rdata_q   <= {DATA_W{1'b0}};
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    assign iob_ready_o   = (state_q == IDLE);
    assign iob_rvalid_o  = rvalid_q;
    assign iob_rdata_o   = rdata_q;
    assign axi_awaddr_o  = addr_q;
    assign axi_awid_o    = ID_W'(AXI_ID);
    assign axi_awlen_o   = {LEN_W{1'b0}};
    assign axi_awsize_o  = AXI_SIZE;
    assign axi_awburst_o = 2'b01;
    assign axi_awvalid_o = awvalid_q;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_wlast_o   = 1'b1;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_bready_o  = (state_q == WRESP);
    assign axi_araddr_o  = addr_q;
    assign axi_arid_o    = ID_W'(AXI_ID);
    assign axi_arlen_o   = {LEN_W{1'b0}};
    assign axi_arsize_o  = AXI_SIZE;
    assign axi_arburst_o = 2'b01;
    assign axi_arvalid_o = arvalid_q;
    assign axi_rready_o  = (state_q == RDATA);
    assign err_o         = err_q;

endmodule

// File: tb/tb_iob_iob2axi_single.sv
// Directed bench for iob_iob2axi_single with a small AXI4 RAM slave model
// whose handshake delays and response codes are set per test.
module tb_iob_iob2axi_single;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        iob_valid_i;
    logic [15:0] iob_addr_i;
    logic [31:0] iob_wdata_i;
    logic [3:0]  iob_wstrb_i;
    logic        iob_ready_o, iob_rvalid_o;
    logic [31:0] iob_rdata_o;
    logic [15:0] axi_awaddr, axi_araddr;
    logic [7:0]  axi_awid, axi_awlen, axi_arid, axi_arlen;
    logic [2:0]  axi_awsize, axi_arsize;
    logic [1:0]  axi_awburst, axi_arburst;
    logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
    logic [31:0] axi_wdata, axi_rdata;
    logic [3:0]  axi_wstrb;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic        axi_rvalid, axi_rready;
    logic        err_o, err_clr_i;

    // slave configuration and observation
    int          aw_dly, w_dly, ar_dly, r_dly;
    logic [1:0]  b_resp, r_resp;
    logic        slv_clr;
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    int          aw_beats = 0, w_beats = 0, b_hs = 0, ar_beats = 0;
    logic        aw_got, w_got, r_pend;
    logic [15:0] aw_addr_s, ar_addr_s;
    logic [31:0] w_data_s;
    logic [3:0]  w_strb_s;
    logic [31:0] mem [0:15];
    logic        aw_hs, w_hs, ar_hs;

    int n_chk = 0, n_pass = 0;
    logic        exp_err;
    logic [31:0] rd;
    int aw0, w0, b0, pulses, rready_seen;

    iob_iob2axi_single dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .iob_valid_i(iob_valid_i), .iob_addr_i(iob_addr_i), .iob_wdata_i(iob_wdata_i),
        .iob_wstrb_i(iob_wstrb_i), .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
        .iob_rdata_o(iob_rdata_o),
        .axi_awaddr_o(axi_awaddr), .axi_awid_o(axi_awid), .axi_awlen_o(axi_awlen),
        .axi_awsize_o(axi_awsize), .axi_awburst_o(axi_awburst), .axi_awvalid_o(axi_awvalid),
        .axi_awready_i(axi_awready),
        .axi_wdata_o(axi_wdata), .axi_wstrb_o(axi_wstrb), .axi_wlast_o(axi_wlast),
        .axi_wvalid_o(axi_wvalid), .axi_wready_i(axi_wready),
        .axi_bresp_i(axi_bresp), .axi_bid_i(8'h00), .axi_bvalid_i(axi_bvalid),
        .axi_bready_o(axi_bready),
        .axi_araddr_o(axi_araddr), .axi_arid_o(axi_arid), .axi_arlen_o(axi_arlen),
        .axi_arsize_o(axi_arsize), .axi_arburst_o(axi_arburst), .axi_arvalid_o(axi_arvalid),
        .axi_arready_i(axi_arready),
        .axi_rdata_i(axi_rdata), .axi_rresp_i(axi_rresp), .axi_rid_i(8'h00),
        .axi_rlast_i(1'b1), .axi_rvalid_i(axi_rvalid), .axi_rready_o(axi_rready),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    assign axi_awready = axi_awvalid && !aw_got && !axi_bvalid && (aw_cnt >= aw_dly);
    assign axi_wready  = axi_wvalid && !w_got && !axi_bvalid && (w_cnt >= w_dly);
    assign axi_arready = axi_arvalid && !r_pend && !axi_rvalid && (ar_cnt >= ar_dly);
    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;
    assign ar_hs = axi_arvalid && axi_arready;

    // AXI RAM slave model
    always @(posedge clk_i) begin
        if (slv_clr) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            axi_bvalid <= 1'b0; axi_rvalid <= 1'b0;
            axi_bresp <= 2'b00; axi_rresp <= 2'b00; axi_rdata <= 32'h0;
        end else begin
            aw_cnt <= (axi_awvalid && !axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi_wvalid && !axi_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (axi_arvalid && !axi_arready) ? ar_cnt + 1 : 0;
            if (aw_hs) begin aw_addr_s <= axi_awaddr; aw_beats <= aw_beats + 1; end
            if (w_hs) begin w_data_s <= axi_wdata; w_strb_s <= axi_wstrb; w_beats <= w_beats + 1; end
            if (axi_bvalid && axi_bready) begin axi_bvalid <= 1'b0; b_hs <= b_hs + 1; end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                mem[aw_hs ? axi_awaddr[5:2] : aw_addr_s[5:2]] <=
                    wmerge(mem[aw_hs ? axi_awaddr[5:2] : aw_addr_s[5:2]],
                           w_hs ? axi_wdata : w_data_s, w_hs ? axi_wstrb : w_strb_s);
                axi_bvalid <= 1'b1;
                axi_bresp  <= b_resp;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= aw_got | aw_hs;
                w_got  <= w_got | w_hs;
            end
            if (axi_rvalid && axi_rready) axi_rvalid <= 1'b0;
            if (ar_hs) begin
                ar_beats <= ar_beats + 1;
                if (r_dly == 0) begin
                    axi_rvalid <= 1'b1; axi_rdata <= mem[axi_araddr[5:2]]; axi_rresp <= r_resp;
                end else begin
                    r_pend <= 1'b1; r_cnt <= 1; ar_addr_s <= axi_araddr;
                end
            end else if (r_pend) begin
                if (r_cnt >= r_dly) begin
                    axi_rvalid <= 1'b1; axi_rdata <= mem[ar_addr_s[5:2]]; axi_rresp <= r_resp;
                    r_pend <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (iob_ready_o) break;
            @(negedge clk_i);
        end
        check(tag, 64'(iob_ready_o), 64'h1);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        iob_valid_i = 1'b1; iob_addr_i = a; iob_wdata_i = d; iob_wstrb_i = s;
        @(negedge clk_i);
        iob_valid_i = 1'b0; iob_wstrb_i = 4'h0;
        wait_ready("wr_done");
    endtask

    task automatic do_read(input logic [15:0] a, output logic [31:0] data);
        logic got;
        got = 1'b0; data = 32'h0;
        iob_valid_i = 1'b1; iob_addr_i = a; iob_wstrb_i = 4'h0;
        @(negedge clk_i);
        iob_valid_i = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk_i);
            if (iob_rvalid_o) begin got = 1'b1; data = iob_rdata_o; end
        end
        check("rd_done", 64'(got), 64'h1);
    endtask

    initial begin
`ifdef IOB2AXI_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_i = 1'b1; iob_valid_i = 1'b0; iob_addr_i = 16'h0; iob_wdata_i = 32'h0;
        iob_wstrb_i = 4'h0; err_clr_i = 1'b0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; b_resp = 2'b00; r_resp = 2'b00;
        slv_clr = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_ready", 64'(iob_ready_o), 64'h1);
        check("rst_rvalid", 64'(iob_rvalid_o), 64'h0);
        check("rst_rdata", 64'(iob_rdata_o), 64'h0);
        check("rst_valids", 64'({axi_awvalid, axi_wvalid, axi_arvalid}), 64'h0);
        check("rst_readys", 64'({axi_bready, axi_rready}), 64'h0);
        check("rst_err", 64'(err_o), 64'h0);
        check("rst_latched", 64'({axi_awaddr, axi_wdata, axi_wstrb}), 64'h0);
        rst_i = 1'b0; slv_clr = 1'b0;
        @(negedge clk_i);

        // write, always-ready slave: cycle-exact
        iob_valid_i = 1'b1; iob_addr_i = 16'h0010; iob_wdata_i = 32'hDEADBEEF; iob_wstrb_i = 4'hF;
        check("w_c0_ready", 64'(iob_ready_o), 64'h1);
        @(negedge clk_i);
        iob_valid_i = 1'b0; iob_wstrb_i = 4'h0;
        check("w_c1_ready", 64'(iob_ready_o), 64'h0);
        check("w_c1_valids", 64'({axi_awvalid, axi_wvalid}), 64'h3);
        check("w_c1_aw", 64'({axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid}),
              64'({16'h0010, 8'h00, 3'd2, 2'b01, 8'h00}));
        check("w_c1_w", 64'({axi_wdata, axi_wstrb, axi_wlast}), 64'({32'hDEADBEEF, 4'hF, 1'b1}));
        @(negedge clk_i);
        check("w_c2_ready", 64'(iob_ready_o), 64'h0);
        check("w_c2_state", 64'({axi_awvalid, axi_wvalid, axi_bready}), 64'h1);
        @(negedge clk_i);
        check("w_c3_ready", 64'(iob_ready_o), 64'h1);
        check("w_c3_quiet", 64'({axi_bready, iob_rvalid_o}), 64'h0);
        check("w_beats", 64'({aw_beats[7:0], w_beats[7:0], b_hs[7:0]}), 64'h010101);

        // read back, cycle-exact, with a new request accepted during the rvalid pulse
        iob_valid_i = 1'b1; iob_addr_i = 16'h0010; iob_wstrb_i = 4'h0;
        @(negedge clk_i);
        iob_valid_i = 1'b0;
        check("r_c1_ar", 64'({axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst}),
              64'({1'b1, 16'h0010, 8'h00, 3'd2, 2'b01}));
        check("r_c1_ready", 64'(iob_ready_o), 64'h0);
        @(negedge clk_i);
        check("r_c2", 64'({axi_arvalid, axi_rready, iob_rvalid_o}), 64'h2);
        @(negedge clk_i);
        check("r_c3_rvalid", 64'({iob_rvalid_o, iob_ready_o}), 64'h3);
        check("r_c3_rdata", 64'(iob_rdata_o), 64'hDEADBEEF);
        iob_valid_i = 1'b1; iob_addr_i = 16'h0030; iob_wdata_i = 32'hFFFFFFFF; iob_wstrb_i = 4'hF;
        @(negedge clk_i);
        iob_valid_i = 1'b0; iob_wstrb_i = 4'h0;
        check("r_c4_pulse", 64'(iob_rvalid_o), 64'h0);
        check("r_c4_hold", 64'(iob_rdata_o), 64'hDEADBEEF);
        check("b2b_accept", 64'({axi_awvalid, axi_awaddr, iob_ready_o}), 64'({1'b1, 16'h0030, 1'b0}));
        wait_ready("b2b_done");

        // delayed awready: W retires first, AW held stable
        aw_dly = 3; aw0 = aw_beats; w0 = w_beats; b0 = b_hs;
        iob_valid_i = 1'b1; iob_addr_i = 16'h0020; iob_wdata_i = 32'h12345678; iob_wstrb_i = 4'hF;
        @(negedge clk_i);
        iob_valid_i = 1'b0; iob_wstrb_i = 4'h0;
        check("d_c1", 64'({axi_awvalid, axi_wvalid}), 64'h3);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk_i);
            check("d_aw_held", 64'({axi_awvalid, axi_wvalid, axi_awaddr}), 64'({2'b10, 16'h0020}));
        end
        wait_ready("d_done");
        check("d_beats", 64'({8'(aw_beats - aw0), 8'(w_beats - w0), 8'(b_hs - b0)}), 64'h010101);
        aw_dly = 0;
        do_read(16'h0020, rd);
        check("d_rdata", 64'(rd), 64'h12345678);

        // partial write into an all-ones word
        do_write(16'h0030, 32'h0000AB00, 4'h2);
        do_read(16'h0030, rd);
        check("p_rdata", 64'(rd), 64'hFFFFABFF);

        // reset while waiting in RDATA
        r_dly = 5;
        iob_valid_i = 1'b1; iob_addr_i = 16'h0010; iob_wstrb_i = 4'h0;
        @(negedge clk_i);
        iob_valid_i = 1'b0;
        @(negedge clk_i);
        check("x_rready", 64'(axi_rready), 64'h1);
        rst_i = 1'b1;
        #1;
        check("x_outs", 64'({axi_rready, iob_rvalid_o, iob_ready_o, axi_arvalid}), 64'h2);
        check("x_rdata", 64'(iob_rdata_o), 64'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        pulses = 0; rready_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (iob_rvalid_o) pulses++;
            if (axi_rready) rready_seen++;
        end
        check("x_slv_rvalid", 64'(axi_rvalid), 64'h1);
        check("x_ignored", 64'({8'(pulses), 8'(rready_seen)}), 64'h0);
        slv_clr = 1'b1; r_dly = 0;
        @(negedge clk_i);
        slv_clr = 1'b0;

        // error flag: R error with a same-cycle clear, then B error
        r_resp = 2'b10;
        iob_valid_i = 1'b1; iob_addr_i = 16'h0010; iob_wstrb_i = 4'h0;
        @(negedge clk_i);
        iob_valid_i = 1'b0;
        @(negedge clk_i);
        check("e_c2", 64'(err_o), 64'h0);
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        check("e_set", 64'(err_o), 64'(exp_err));
        check("e_rdata", 64'({iob_rvalid_o, iob_rdata_o}), 64'({1'b1, 32'hDEADBEEF}));
        repeat (3) @(negedge clk_i);
        check("e_held", 64'(err_o), 64'(exp_err));
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        check("e_clr", 64'(err_o), 64'h0);
        r_resp = 2'b00; b_resp = 2'b10;
        do_write(16'h0024, 32'h00000055, 4'hF);
        b_resp = 2'b00;
        check("e_bset", 64'(err_o), 64'(exp_err));
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        check("e_bclr", 64'(err_o), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/iob_iob2axi_single.md
# iob_iob2axi_single

Single-beat bridge from the IOb native bus to an AXI4 master port. It accepts one IOb read or write request at a time, converts it into one AXI4 transaction (LEN=0, INCR), and completes the IOb request when the AXI response returns. It sits directly upstream of the AXI4 RAM and feeds its slave interface from a CPU or peripheral IOb master.

## Interface
- ADDR_W, 16, byte address width (IOb and AXI)
- DATA_W, 32, data width; DATA_W/8 strobe bits; power-of-two multiple of 8
- ID_W, 8, AXI ID width
- LEN_W, 8, AXI len width
- AXI_ID, 0, constant ID driven on awid/arid
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- iob_valid_i  in  1  request valid
- iob_addr_i  in  ADDR_W  byte address
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  DATA_W/8  byte enables; nonzero = write, zero = read
- iob_ready_o  out  1  request accepted when valid_i & ready_o
- iob_rvalid_o  out  1  one-cycle read-data pulse
- iob_rdata_o  out  DATA_W  read data, valid with rvalid_o
- axi_aw{addr,id,len,size,burst,valid}_o / axi_awready_i; axi_w{data,strb,last,valid}_o / axi_wready_i; axi_b{resp,id,valid}_i / axi_bready_o; axi_ar{addr,id,len,size,burst,valid}_o / axi_arready_i; axi_r{data,resp,id,last,valid}_i / axi_rready_o — standard AXI4 widths per parameters
- err_o  out  1  sticky non-OKAY response flag
- err_clr_i  in  1  clears err_o

## Operation
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA.
- iob_ready_o = (state == IDLE); combinational from state register.
- IDLE, accept with wstrb≠0: latch addr/wdata/wstrb; set awvalid and wvalid registers; -> WRITE.
- WRITE: awvalid drops on awvalid&awready, wvalid drops on wvalid&wready, independently, any order or same cycle. Both complete -> WRESP.
- WRESP: bready_o=1; on bvalid -> IDLE. No iob_rvalid_o for writes.
- IDLE, accept with wstrb=0: latch addr; set arvalid; -> RADDR. On arready -> RDATA.
- RDATA: rready_o=1; on rvalid register rdata into iob_rdata_o, pulse iob_rvalid_o next cycle; -> IDLE.
- Constant AXI fields: len=0, size=$clog2(DATA_W/8), burst=2'b01, wlast=1, id=AXI_ID. Addresses passed unmodified; strobes passed unmodified.
- bid/rid/rlast ignored. iob_rdata_o holds last read value until next read completes.
- Valid signals never drop before handshake (AXI rule); latched payload stable while valid.

## Timing
- Reset values: iob_ready_o=1 (state IDLE), iob_rvalid_o=0, iob_rdata_o=0, all axi_*valid_o=0, bready_o=0, rready_o=0, err_o=0, latched addr/data/strb=0.
- Reset mid-transaction: all outputs return to reset values immediately (async); in-flight AXI transaction abandoned.
- Request accepted cycle 0 → AW/W or AR valid from cycle 1.
- Write, always-ready slave: AW+W handshake cycle 1, bvalid cycle 2, ready_o high cycle 3. Against the AXI RAM (wready registered): W handshake cycle 2, ready_o ≥ cycle 4.
- Read, always-ready slave with rvalid cycle 2: iob_rvalid_o cycle 3, ready_o high cycle 3; a new request may be accepted the same cycle rvalid_o pulses.
- One outstanding transaction maximum; no pipelining.
- bvalid/rvalid arriving outside WRESP/RDATA cannot be acknowledged (bready/rready=0).

## Configuration
- Macro IOB2AXI_ERR_EN.
- Defined: err_o sets on accepted B or R beat with resp≠2'b00; stays set until err_clr_i (clear wins over same-cycle set? No: set wins); reset clears.
- Undefined: err_o tied 0, err_clr_i and resp inputs ignored.

## Test plan
- Write addr 0x0010, wdata 0xDEADBEEF, wstrb 0xF, slave always ready -> one AW (addr 0x0010, len 0, size 2, burst 1) and W (wlast 1) beat, ready_o low cycles 1-2, high cycle 3.
- Write then read 0x0010 against AXI RAM -> iob_rvalid_o single pulse with iob_rdata_o=0xDEADBEEF.
- Slave delays awready 3 cycles, wready 0 cycles -> wvalid drops after cycle 1, awvalid held stable 3 cycles with unchanged addr; single bready handshake.
- Partial write wstrb 0x2, wdata 0x0000AB00 to word 0xFFFFFFFF -> read returns 0xFFFFABFF.
- Assert rst_i while in RDATA -> rready_o, iob_rvalid_o=0 immediately, ready_o=1; later rvalid ignored.
- With IOB2AXI_ERR_EN: rresp=2'b10 -> err_o=1 next cycle, held until err_clr_i pulse; without macro err_o stays 0.
